// File: rtl/siso_tx_arbiter.sv
// siso_tx_arbiter: round-robin arbiter of two parallel producers feeding an MSB-first serial shifter with idle gap
module siso_tx_arbiter #(
  parameter int W = 8,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         reset_ah_in,
  input  logic         req0_in,
  input  logic [W-1:0] data0_in,
  input  logic         req1_in,
  input  logic [W-1:0] data1_in,
  output logic         ack0_out,
  output logic         ack1_out,
  output logic         sd_out,
  output logic         sd_valid_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         done_id_out
);
  localparam int CW = $clog2(W);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
  state_t state, nxt;
  logic [W-1:0] sreg;
  logic [CW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic last_grant, ack0, ack1, done, done_id;
  logic any_req, win, grant, last_bit, gap_end;
  assign any_req = req0_in | req1_in;
  assign win = (req0_in & req1_in) ? ~last_grant : req1_in;
  assign grant = (state == ST_IDLE) & any_req;
  assign last_bit = bit_cnt == CW'(W - 1);
  generate
    if (GAP > 0) begin : g_gap
      assign gap_end = gap_cnt == GW'(GAP - 1);
    end else begin : g_nogap
      assign gap_end = 1'b1;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      state <= ST_IDLE;
      sreg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      last_grant <= 1'b1;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      done_id <= 1'b0;
    end else begin
      state <= nxt;
      ack0 <= grant & ~win;
      ack1 <= grant & win;
      done <= (state == ST_SHIFT) & last_bit;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
      if ((state == ST_SHIFT) & last_bit) done_id <= last_grant;
      if (grant) begin
        sreg <= win ? data1_in : data0_in;
        last_grant <= win;
        bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        sreg <= {sreg[W-2:0], 1'b0};
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end
  always_comb begin
    nxt = state;
    if (grant) nxt = ST_SHIFT;
    if ((state == ST_SHIFT) & last_bit) nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
    if ((state == ST_GAP) & gap_end) nxt = ST_IDLE;
  end
  always_comb begin
    sd_valid_out = state == ST_SHIFT;
    sd_out = sd_valid_out & sreg[W-1];
    busy_out = state != ST_IDLE;
  end
  assign ack0_out = ack0;
  assign ack1_out = ack1;
  assign done_out = done;
  assign done_id_out = done_id;
endmodule
